// File: rtl/bram_port_arbiter_pkg.sv
// bram_port_arbiter_pkg: shared widths, FSM encoding, transaction record and legality rule
package bram_port_arbiter_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0] BE_FULL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic              port;
        logic              we;
        logic              bad;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdat;
        logic [BE_W-1:0]   be;
    } txn_t;

    // An empty mask, or a full-word mask on a misaligned address, is rejected.
    function automatic logic legal(logic [1:0] lo, logic [BE_W-1:0] be);
        return be != '0 && !(be == BE_FULL && lo != 2'b00);
    endfunction
endpackage

// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: two requester ports (indexed by port id) plus the BRAM side
interface bram_port_arbiter_if #(
    parameter int ADDR_W = bram_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W = bram_port_arbiter_pkg::DATA_W
);
    logic              req [2];
    logic              we [2];
    logic [ADDR_W-1:0] addr [2];
    logic [DATA_W-1:0] wdat [2];
    logic [3:0]        be [2];
    logic              gnt [2];
    logic              done [2];
    logic              err [2];
    logic [DATA_W-1:0] rdat [2];
    logic [ADDR_W-1:0] mem_w_addr;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [DATA_W-1:0] mem_w_dat;
    logic [DATA_W-1:0] mem_r_dat;
    logic              mem_w_enb;
    logic              mem_r_enb;
    logic [3:0]        mem_byte_enb;

    modport master (
        output req, we, addr, wdat, be, mem_r_dat,
        input  gnt, done, err, rdat, mem_w_addr, mem_r_addr, mem_w_dat, mem_w_enb, mem_r_enb, mem_byte_enb
    );
    modport slave (
        input  req, we, addr, wdat, be, mem_r_dat,
        output gnt, done, err, rdat, mem_w_addr, mem_r_addr, mem_w_dat, mem_w_enb, mem_r_enb, mem_byte_enb
    );
endinterface

// File: rtl/bram_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin; on a tie the port other than the last winner is granted
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic last;
    assign gnt[0] = en && req[0] && (!req[1] || last);
    assign gnt[1] = en && req[1] && (!req[0] || !last);
    always_ff @(posedge clk) begin
        if (rst) last <= 1'b1;
        else if (|gnt) last <= gnt[1];
    end
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: serialises two requesters onto a single-port BRAM, one access per ACCESS cycle
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
(
    input logic clk,
    input logic rst,
    bram_port_arbiter_if.slave bus
);
    state_t state;
    txn_t txn;
    logic [DATA_W-1:0] rdat [2];
    logic [1:0] req, gnt;
    logic en, sel, acc, ok;

    assign req = {bus.req[1], bus.req[0]};
    assign en = !rst && state != ACCESS;
    assign acc = !rst && state == ACCESS;
    assign sel = gnt[1];
    assign ok = legal(bus.addr[sel][1:0], bus.be[sel]);

    rr_arbiter2 u_arb (.clk(clk), .rst(rst), .req(req), .en(en), .gnt(gnt));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            txn <= '0;
            rdat <= '{default: '0};
        end else if (state == ACCESS) begin
            state <= RESP;
            if (!txn.we) rdat[txn.port] <= bus.mem_r_dat;
        end else if (|gnt) begin
            txn <= '{port: sel, we: bus.we[sel], bad: !ok, addr: bus.addr[sel], wdat: bus.wdat[sel], be: bus.be[sel]};
            state <= ok ? ACCESS : RESP;
        end else begin
            state <= IDLE;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign bus.gnt[p] = gnt[p];
        assign bus.done[p] = !rst && state == RESP && txn.port == 1'(p);
        assign bus.err[p] = bus.done[p] && txn.bad;
        assign bus.rdat[p] = rst ? '0 : rdat[p];
    end

    // Rejected transactions skip ACCESS, so they can never raise an enable.
    assign bus.mem_w_enb = acc && txn.we;
    assign bus.mem_r_enb = acc && !txn.we;
    assign bus.mem_w_addr = bus.mem_w_enb ? txn.addr : '0;
    assign bus.mem_r_addr = bus.mem_r_enb ? txn.addr : '0;
    assign bus.mem_w_dat = bus.mem_w_enb ? txn.wdat : '0;
    assign bus.mem_byte_enb = bus.mem_w_enb ? txn.be : '0;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed vector table, arbitration/reset sequences and random traffic vs a reference memory
module tb_bram_port_arbiter;
    import bram_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_port_arbiter_if bus ();
    bram_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DATA_W-1:0] bram [1024];
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) bram[i] <= '0;
        end else if (bus.mem_w_enb) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_byte_enb[b]) bram[bus.mem_w_addr[ADDR_W-1:2]][8*b +: 8] <= bus.mem_w_dat[8*b +: 8];
        end
    end
    assign bus.mem_r_dat = bus.mem_r_enb ? bram[bus.mem_r_addr[ADDR_W-1:2]] : '0;

    typedef struct {
        int          port;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdat;
        logic [3:0]  be;
        logic        err;
        int          lat;
        logic [31:0] rdat;
    } vec_t;

    vec_t v [11];
    logic [31:0] ref_mem [1024];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{bus.gnt[0], bus.gnt[1], bus.done[0], bus.done[1], bus.err[0], bus.err[1],
                 bus.rdat[0], bus.rdat[1], bus.mem_w_addr, bus.mem_r_addr, bus.mem_w_dat,
                 bus.mem_w_enb, bus.mem_r_enb, bus.mem_byte_enb};
    endfunction

    task automatic idle_inputs();
        for (int p = 0; p < 2; p++) begin
            bus.req[p] = 1'b0;
            bus.we[p] = 1'b0;
            bus.addr[p] = '0;
            bus.wdat[p] = '0;
            bus.be[p] = '0;
        end
    endtask

    task automatic do_reset(input logic wipe);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        clr = wipe;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;
    endtask

    task automatic drive(input int p, input logic we, input logic [11:0] addr, input logic [31:0] wdat, input logic [3:0] be);
        bus.req[p] = 1'b1;
        bus.we[p] = we;
        bus.addr[p] = addr;
        bus.wdat[p] = wdat;
        bus.be[p] = be;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        int w, lat, wen, ren;
        @(negedge clk);
        drive(t.port, t.we, t.addr, t.wdat, t.be);
        #1;
        w = 0;
        while (!bus.gnt[t.port] && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk($sformatf("vec%0d_gnt", idx), bus.gnt[t.port], 1);
        @(negedge clk);
        bus.req[t.port] = 1'b0;
        wen = 0;
        ren = 0;
        for (lat = 1; lat < 10; lat++) begin
            wen += int'(bus.mem_w_enb);
            ren += int'(bus.mem_r_enb);
            if (bus.done[t.port]) break;
            @(negedge clk);
        end
        chk($sformatf("vec%0d_lat", idx), lat, t.lat);
        chk($sformatf("vec%0d_err", idx), bus.err[t.port], t.err);
        chk($sformatf("vec%0d_rdat", idx), bus.rdat[t.port], t.rdat);
        chk($sformatf("vec%0d_wen", idx), wen, (!t.err && t.we) ? 1 : 0);
        chk($sformatf("vec%0d_ren", idx), ren, (!t.err && !t.we) ? 1 : 0);
    endtask

    initial begin
        int gp[$], gc[$];
        logic pend [2], drop [2];
        logic exp_err [2];
        logic [31:0] exp_rdat [2], cur_rdat [2];
        int gwait [2], pwait [2];

        v[0]  = '{0, 1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, 1'b0, 2, 32'h0};
        v[1]  = '{0, 1'b0, 12'h010, 32'h0,        4'b1111, 1'b0, 2, 32'hDEADBEEF};
        v[2]  = '{1, 1'b1, 12'h010, 32'h11223344, 4'b1111, 1'b0, 2, 32'h0};
        v[3]  = '{1, 1'b1, 12'h011, 32'h0000AB00, 4'b0010, 1'b0, 2, 32'h0};
        v[4]  = '{1, 1'b0, 12'h010, 32'h0,        4'b1111, 1'b0, 2, 32'h1122AB44};
        v[5]  = '{0, 1'b0, 12'h006, 32'h0,        4'b1111, 1'b1, 1, 32'hDEADBEEF};
        v[6]  = '{0, 1'b0, 12'h010, 32'h0,        4'b0000, 1'b1, 1, 32'hDEADBEEF};
        v[7]  = '{0, 1'b1, 12'h003, 32'h77000000, 4'b1000, 1'b0, 2, 32'hDEADBEEF};
        v[8]  = '{0, 1'b0, 12'h000, 32'h0,        4'b1111, 1'b0, 2, 32'h77000000};
        v[9]  = '{1, 1'b1, 12'h005, 32'hCAFEF00D, 4'b1111, 1'b1, 1, 32'h1122AB44};
        v[10] = '{1, 1'b0, 12'h004, 32'h0,        4'b1111, 1'b0, 2, 32'h0};

        idle_inputs();
        repeat (3) @(negedge clk);
        chk("reset_outputs", any_out(), 0);
        rst = 1'b0;
        clr = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(v[i], i);

        // Tie at cycle 5 after reset, then alternation under continuous requests.
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        drive(0, 1'b0, 12'h010, 32'h0, 4'b1111);
        drive(1, 1'b0, 12'h020, 32'h0, 4'b1111);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("gnt_onehot", bus.gnt[0] && bus.gnt[1], 0);
            if (bus.gnt[0]) begin gp.push_back(0); gc.push_back(c); end
            if (bus.gnt[1]) begin gp.push_back(1); gc.push_back(c); end
        end
        chk("tie_count", gp.size(), 6);
        for (int i = 0; i < gp.size(); i++) begin
            chk($sformatf("tie_port%0d", i), gp[i], i % 2);
            chk($sformatf("tie_cycle%0d", i), gc[i], 2 * i);
        end
        idle_inputs();
        repeat (4) @(negedge clk);

        // Reset during ACCESS of a port 1 write.
        drive(1, 1'b1, 12'h040, 32'h00000055, 4'b1111);
        #1;
        chk("rst_seq_gnt1", bus.gnt[1], 1);
        @(negedge clk);
        bus.req[1] = 1'b0;
        chk("rst_seq_wen", bus.mem_w_enb, 1);
        rst = 1'b1;
        #1;
        chk("rst_seq_forced", any_out(), 0);
        @(negedge clk);
        chk("rst_seq_after", any_out(), 0);
        rst = 1'b0;
        drive(0, 1'b0, 12'h040, 32'h0, 4'b1111);
        drive(1, 1'b0, 12'h040, 32'h0, 4'b1111);
        #1;
        chk("rst_seq_done1", bus.done[1], 0);
        chk("rst_seq_tie", {bus.gnt[1], bus.gnt[0]}, 2'b01);
        idle_inputs();
        repeat (4) @(negedge clk);

        // Random traffic against a reference memory, applied in grant order.
        do_reset(1'b1);
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0;
            drop[p] = 1'b0;
            exp_err[p] = 1'b0;
            exp_rdat[p] = '0;
            cur_rdat[p] = '0;
            gwait[p] = 0;
            pwait[p] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (bus.mem_w_enb && bus.mem_r_enb) chk("rnd_enable_overlap", 1, 0);
            for (int p = 0; p < 2; p++) begin
                if (bus.done[p]) begin
                    if (!pend[p]) chk($sformatf("rnd_spurious_done%0d", p), 1, 0);
                    else begin
                        chk($sformatf("rnd_err%0d", p), bus.err[p], exp_err[p]);
                        chk($sformatf("rnd_rdat%0d", p), bus.rdat[p], exp_rdat[p]);
                    end
                    pend[p] = 1'b0;
                end else if (pend[p] && ++pwait[p] > 4) begin
                    chk($sformatf("rnd_done_timeout%0d", p), 0, 1);
                    pend[p] = 1'b0;
                end
                if (drop[p]) begin
                    bus.req[p] = 1'b0;
                    drop[p] = 1'b0;
                end else if (!bus.req[p] && !pend[p] && $urandom_range(0, 2) == 0) begin
                    logic [11:0] a;
                    logic [3:0] be;
                    a = 12'($urandom_range(0, 63));
                    be = ($urandom_range(0, 7) < 3) ? 4'b1111 : 4'($urandom_range(0, 15));
                    if (be == 4'b1111 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                    drive(p, 1'($urandom_range(0, 1)), a, $urandom, be);
                    gwait[p] = 0;
                end
            end
            #1;
            if (bus.gnt[0] && bus.gnt[1]) chk("rnd_gnt_onehot", 1, 0);
            for (int p = 0; p < 2; p++) begin
                if (bus.req[p] && bus.gnt[p]) begin
                    logic [9:0] w;
                    logic ok;
                    w = bus.addr[p][11:2];
                    ok = bus.be[p] != 4'b0000 && !(bus.be[p] == 4'b1111 && bus.addr[p][1:0] != 2'b00);
                    exp_err[p] = !ok;
                    if (ok && bus.we[p]) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.be[p][b]) ref_mem[w][8*b +: 8] = bus.wdat[p][8*b +: 8];
                    end else if (ok) begin
                        cur_rdat[p] = ref_mem[w];
                    end
                    exp_rdat[p] = cur_rdat[p];
                    pend[p] = 1'b1;
                    pwait[p] = 0;
                    drop[p] = 1'b1;
                end else if (bus.req[p] && ++gwait[p] > 8) begin
                    chk($sformatf("rnd_gnt_timeout%0d", p), 0, 1);
                    gwait[p] = 0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
